// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-client memory arbiter: state encoding,
// client ids and memory-port geometry.
package mem_arbiter_pkg;

  localparam int WORD_ADDR_BITS    = 30;
  localparam int MEM_DATA_BITS_DEF = 128;
  localparam int MEM_ADDR_BITS_DEF = WORD_ADDR_BITS - 2;
  localparam int MASK_BITS_DEF     = MEM_DATA_BITS_DEF / 8;

  localparam logic CLIENT_IC = 1'b0;
  localparam logic CLIENT_DC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // On a tie the client that did not win last time gets the grant.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    logic pick;
    case (req)
      2'b01:   pick = CLIENT_IC;
      2'b10:   pick = CLIENT_DC;
      2'b11:   pick = ~last;
      default: pick = last;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin grant. last_grant advances only when the granted
// client actually completes its request handshake.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       update_id_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  logic last_grant_q;
  logic last_grant_d;

  // Grant selection from current requests and fairness history.
  always_comb begin
    grant_valid_o = |req_i;
    grant_id_o    = rr_pick(req_i, last_grant_q);
    if (update_i) begin
      last_grant_d = update_id_i;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Fairness history register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_grant_q <= CLIENT_IC;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Merges the instruction- and data-cache memory ports onto one backing
// memory port, one transaction at a time, with a combinational datapath.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_DATA_BITS = MEM_DATA_BITS_DEF,
  parameter int MEM_ADDR_BITS = MEM_ADDR_BITS_DEF,
  parameter int MASK_BITS     = MEM_DATA_BITS / 8
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     ic_mem_req_valid,
  output logic                     ic_mem_req_ready,
  input  logic [MEM_ADDR_BITS-1:0] ic_mem_req_addr,
  input  logic                     ic_mem_req_rw,
  input  logic                     ic_mem_req_data_valid,
  output logic                     ic_mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] ic_mem_req_data_bits,
  input  logic [MASK_BITS-1:0]     ic_mem_req_data_mask,
  output logic                     ic_mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0] ic_mem_resp_data,

  input  logic                     dc_mem_req_valid,
  output logic                     dc_mem_req_ready,
  input  logic [MEM_ADDR_BITS-1:0] dc_mem_req_addr,
  input  logic                     dc_mem_req_rw,
  input  logic                     dc_mem_req_data_valid,
  output logic                     dc_mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] dc_mem_req_data_bits,
  input  logic [MASK_BITS-1:0]     dc_mem_req_data_mask,
  output logic                     dc_mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0] dc_mem_resp_data,

  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic                     mem_req_rw,
  output logic                     mem_req_data_valid,
  input  logic                     mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
  output logic [MASK_BITS-1:0]     mem_req_data_mask,
  input  logic                     mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_resp_data,

  output logic                     protocol_err
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       err_q, err_d;

  logic                     grant_valid_s;
  logic                     grant_id_s;
  logic                     own_req_valid_s;
  logic                     own_rw_s;
  logic                     own_data_valid_s;
  logic [MEM_ADDR_BITS-1:0] own_addr_s;
  logic [MEM_DATA_BITS-1:0] own_bits_s;
  logic [MASK_BITS-1:0]     own_mask_s;
  logic                     in_req_s;
  logic                     in_wdata_s;
  logic                     req_hs_s;
  logic                     fwd_s;
  logic                     unexpected_s;
  logic                     own_is_dc_s;

  rr_arb2 u_rr_arb2 (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_i         ({dc_mem_req_valid, ic_mem_req_valid}),
    .update_i      (req_hs_s),
    .update_id_i   (owner_q),
    .grant_valid_o (grant_valid_s),
    .grant_id_o    (grant_id_s)
  );

  // Owner-side request/data selection; the other client never leaks through.
  always_comb begin
    own_is_dc_s = (owner_q == CLIENT_DC);
    if (own_is_dc_s) begin
      own_req_valid_s  = dc_mem_req_valid;
      own_rw_s         = dc_mem_req_rw;
      own_addr_s       = dc_mem_req_addr;
      own_data_valid_s = dc_mem_req_data_valid;
      own_bits_s       = dc_mem_req_data_bits;
      own_mask_s       = dc_mem_req_data_mask;
    end else begin
      own_req_valid_s  = ic_mem_req_valid;
      own_rw_s         = ic_mem_req_rw;
      own_addr_s       = ic_mem_req_addr;
      own_data_valid_s = ic_mem_req_data_valid;
      own_bits_s       = ic_mem_req_data_bits;
      own_mask_s       = ic_mem_req_data_mask;
    end
  end

  // Handshake qualifiers; everything is gated off while reset is high.
  always_comb begin
    in_req_s     = (state_q == ST_REQ)   && !reset;
    in_wdata_s   = (state_q == ST_WDATA) && !reset;
    req_hs_s     = in_req_s && own_req_valid_s && mem_req_ready;
    fwd_s        = !reset && mem_resp_valid &&
                   ((state_q == ST_RESP) || (req_hs_s && !own_rw_s));
    unexpected_s = mem_resp_valid &&
                   ((state_q == ST_IDLE) || (state_q == ST_WDATA));
  end

  // Next-state logic for the transaction FSM.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    err_d   = err_q | unexpected_s;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          owner_d = grant_id_s;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!own_req_valid_s) begin
          state_d = ST_IDLE;
        end else if (mem_req_ready) begin
          if (own_rw_s) begin
            state_d = ST_WDATA;
          end else if (mem_resp_valid) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WDATA: begin
        if (own_data_valid_s && mem_req_data_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_RESP: begin
        if (mem_resp_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, owner and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= CLIENT_IC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // Memory-side and client-side output muxing.
  always_comb begin
    mem_req_valid         = in_req_s && own_req_valid_s;
    mem_req_addr          = own_addr_s;
    mem_req_rw            = own_rw_s;
    mem_req_data_valid    = in_wdata_s && own_data_valid_s;
    mem_req_data_bits     = own_bits_s;
    mem_req_data_mask     = own_mask_s;

    ic_mem_req_ready      = in_req_s   && !own_is_dc_s && mem_req_ready;
    dc_mem_req_ready      = in_req_s   &&  own_is_dc_s && mem_req_ready;
    ic_mem_req_data_ready = in_wdata_s && !own_is_dc_s && mem_req_data_ready;
    dc_mem_req_data_ready = in_wdata_s &&  own_is_dc_s && mem_req_data_ready;

    ic_mem_resp_valid     = fwd_s && !own_is_dc_s;
    dc_mem_resp_valid     = fwd_s &&  own_is_dc_s;
    ic_mem_resp_data      = mem_resp_data;
    dc_mem_resp_data      = mem_resp_data;

    protocol_err          = err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expectations are queued by the directed
// stimulus and consumed by an independent negedge monitor.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int DW = 128;
  localparam int AW = 28;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_mem_req_valid, ic_mem_req_ready, ic_mem_req_rw;
  logic [AW-1:0] ic_mem_req_addr;
  logic          ic_mem_req_data_valid, ic_mem_req_data_ready;
  logic [DW-1:0] ic_mem_req_data_bits, ic_mem_resp_data;
  logic [MW-1:0] ic_mem_req_data_mask;
  logic          ic_mem_resp_valid;
  logic          dc_mem_req_valid, dc_mem_req_ready, dc_mem_req_rw;
  logic [AW-1:0] dc_mem_req_addr;
  logic          dc_mem_req_data_valid, dc_mem_req_data_ready;
  logic [DW-1:0] dc_mem_req_data_bits, dc_mem_resp_data;
  logic [MW-1:0] dc_mem_req_data_mask;
  logic          dc_mem_resp_valid;
  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [DW-1:0] mem_req_data_bits, mem_resp_data;
  logic [MW-1:0] mem_req_data_mask;
  logic          mem_resp_valid;
  logic          protocol_err;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_mem_req_valid(ic_mem_req_valid), .ic_mem_req_ready(ic_mem_req_ready),
    .ic_mem_req_addr(ic_mem_req_addr), .ic_mem_req_rw(ic_mem_req_rw),
    .ic_mem_req_data_valid(ic_mem_req_data_valid), .ic_mem_req_data_ready(ic_mem_req_data_ready),
    .ic_mem_req_data_bits(ic_mem_req_data_bits), .ic_mem_req_data_mask(ic_mem_req_data_mask),
    .ic_mem_resp_valid(ic_mem_resp_valid), .ic_mem_resp_data(ic_mem_resp_data),
    .dc_mem_req_valid(dc_mem_req_valid), .dc_mem_req_ready(dc_mem_req_ready),
    .dc_mem_req_addr(dc_mem_req_addr), .dc_mem_req_rw(dc_mem_req_rw),
    .dc_mem_req_data_valid(dc_mem_req_data_valid), .dc_mem_req_data_ready(dc_mem_req_data_ready),
    .dc_mem_req_data_bits(dc_mem_req_data_bits), .dc_mem_req_data_mask(dc_mem_req_data_mask),
    .dc_mem_resp_valid(dc_mem_resp_valid), .dc_mem_resp_data(dc_mem_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] addr; logic rw; } req_t;
  typedef struct packed { logic client; logic [DW-1:0] data; } resp_t;
  typedef struct packed { logic [DW-1:0] bits; logic [MW-1:0] mask; } wdat_t;

  req_t  exp_req[$];
  resp_t exp_resp[$];
  wdat_t exp_wdat[$];
  req_t  m_req;
  resp_t m_resp;
  wdat_t m_wdat;

  int   checks = 0;
  int   errors = 0;
  logic chk_ic_ready_zero = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  // Monitor: every handshake / response the DUT presents consumes one expectation.
  always @(negedge clk) begin
    if (ic_mem_resp_valid || dc_mem_resp_valid) begin
      if (exp_resp.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp ic=%0b dc=%0b required none", ic_mem_resp_valid, dc_mem_resp_valid);
      end else begin
        m_resp = exp_resp.pop_front();
        check("resp_ic_valid", ic_mem_resp_valid, m_resp.client == CLIENT_IC);
        check("resp_dc_valid", dc_mem_resp_valid, m_resp.client == CLIENT_DC);
        check("resp_ic_data", ic_mem_resp_data, m_resp.data);
        check("resp_dc_data", dc_mem_resp_data, m_resp.data);
      end
    end
    if (mem_req_valid && mem_req_ready) begin
      if (exp_req.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_mem_req addr=%0h required none", mem_req_addr);
      end else begin
        m_req = exp_req.pop_front();
        check("mem_req_addr", mem_req_addr, m_req.addr);
        check("mem_req_rw", mem_req_rw, m_req.rw);
      end
    end
    if (mem_req_data_valid && mem_req_data_ready) begin
      if (exp_wdat.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_data_beat bits=%0h required none", mem_req_data_bits);
      end else begin
        m_wdat = exp_wdat.pop_front();
        check("mem_data_bits", mem_req_data_bits, m_wdat.bits);
        check("mem_data_mask", mem_req_data_mask, m_wdat.mask);
      end
    end
    if (chk_ic_ready_zero) begin
      check("ic_ready_zero", ic_mem_req_ready, 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req_valid && mem_req_ready) && n < 20);
    if (!(mem_req_valid && mem_req_ready)) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_accept required=accept", name);
    end
  endtask

  task automatic clear_inputs();
    ic_mem_req_valid = 1'b0; ic_mem_req_addr = '0; ic_mem_req_rw = 1'b0;
    ic_mem_req_data_valid = 1'b0; ic_mem_req_data_bits = '0; ic_mem_req_data_mask = '0;
    dc_mem_req_valid = 1'b0; dc_mem_req_addr = '0; dc_mem_req_rw = 1'b0;
    dc_mem_req_data_valid = 1'b0; dc_mem_req_data_bits = '0; dc_mem_req_data_mask = '0;
    mem_req_ready = 1'b1; mem_req_data_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [DW-1:0] wbits;

  initial begin
    clear_inputs();
    // Reset with both clients and a stray response active: everything must read 0.
    reset = 1'b1;
    ic_mem_req_valid = 1'b1; dc_mem_req_valid = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = fill(8'hEE);
    step();
    @(negedge clk);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_ic_req_ready", ic_mem_req_ready, 1'b0);
    check("rst_dc_req_ready", dc_mem_req_ready, 1'b0);
    check("rst_mem_data_valid", mem_req_data_valid, 1'b0);
    check("rst_protocol_err", protocol_err, 1'b0);
    step();
    reset = 1'b0;
    clear_inputs();

    // 1: ic read alone, response 2 cycles after accept.
    exp_req.push_back('{addr: 28'h0000123, rw: 1'b0});
    exp_resp.push_back('{client: CLIENT_IC, data: fill(8'hA5)});
    ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000123; ic_mem_req_rw = 1'b0;
    wait_accept("t1_accept");
    step();
    ic_mem_req_valid = 1'b0;
    step();
    mem_resp_valid = 1'b1; mem_resp_data = fill(8'hA5);
    step();
    mem_resp_valid = 1'b0;
    check("t1_resp_drained", exp_resp.size(), 0);

    // 2: three ties after reset go dc, ic, dc.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        exp_req.push_back('{addr: 28'h0000111, rw: 1'b0});
        exp_resp.push_back('{client: CLIENT_IC, data: fill(8'h10 + 8'(i))});
      end else begin
        exp_req.push_back('{addr: 28'h0000222, rw: 1'b0});
        exp_resp.push_back('{client: CLIENT_DC, data: fill(8'h10 + 8'(i))});
      end
      ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000111; ic_mem_req_rw = 1'b0;
      dc_mem_req_valid = 1'b1; dc_mem_req_addr = 28'h0000222; dc_mem_req_rw = 1'b0;
      wait_accept("t2_accept");
      step();
      ic_mem_req_valid = 1'b0; dc_mem_req_valid = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = fill(8'h10 + 8'(i));
      step();
      mem_resp_valid = 1'b0;
    end
    check("t2_resp_drained", exp_resp.size(), 0);

    // 3: dc write with slow data_ready; ic waits behind it.
    wbits = 128'h00112233445566778899AABBCCDDEEFF;
    exp_req.push_back('{addr: 28'h0ABCDEF, rw: 1'b1});
    exp_wdat.push_back('{bits: wbits, mask: 16'hFFFF});
    exp_req.push_back('{addr: 28'h0000333, rw: 1'b0});
    exp_resp.push_back('{client: CLIENT_IC, data: fill(8'h3C)});
    mem_req_data_ready = 1'b0;
    chk_ic_ready_zero = 1'b1;
    dc_mem_req_valid = 1'b1; dc_mem_req_addr = 28'h0ABCDEF; dc_mem_req_rw = 1'b1;
    wait_accept("t3_accept");
    step();
    dc_mem_req_valid = 1'b0;
    ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000333; ic_mem_req_rw = 1'b0;
    step();
    dc_mem_req_data_valid = 1'b1; dc_mem_req_data_bits = wbits; dc_mem_req_data_mask = 16'hFFFF;
    step(); step(); step();
    mem_req_data_ready = 1'b1;
    step();
    dc_mem_req_data_valid = 1'b0;
    chk_ic_ready_zero = 1'b0;
    check("t3_wdata_drained", exp_wdat.size(), 0);
    wait_accept("t3_ic_accept");
    step();
    ic_mem_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = fill(8'h3C);
    step();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("t3_resp_drained", exp_resp.size(), 0);
    check("t3_err_clear", protocol_err, 1'b0);

    // 4: stray response in IDLE sets the sticky error.
    step();
    mem_resp_valid = 1'b1; mem_resp_data = fill(8'h77);
    step();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("t4_err_set", protocol_err, 1'b1);
    step(); step(); step();
    @(negedge clk);
    check("t4_err_sticky", protocol_err, 1'b1);
    step();
    reset_dut();
    @(negedge clk);
    check("t4_err_reset", protocol_err, 1'b0);

    // 5: read accepted together with its response, then straight back to IDLE.
    step();
    exp_req.push_back('{addr: 28'h0000055, rw: 1'b0});
    exp_resp.push_back('{client: CLIENT_IC, data: fill(8'h55)});
    exp_req.push_back('{addr: 28'h0000056, rw: 1'b0});
    exp_resp.push_back('{client: CLIENT_IC, data: fill(8'h56)});
    ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000055; ic_mem_req_rw = 1'b0;
    step();
    mem_resp_valid = 1'b1; mem_resp_data = fill(8'h55);
    step();
    mem_resp_valid = 1'b0; ic_mem_req_addr = 28'h0000056;
    @(negedge clk);
    check("t5_idle_no_req", mem_req_valid, 1'b0);
    step();
    @(negedge clk);
    check("t5_next_req_valid", mem_req_valid, 1'b1);
    step();
    ic_mem_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = fill(8'h56);
    step();
    mem_resp_valid = 1'b0;
    check("t5_resp_drained", exp_resp.size(), 0);

    // 6: reset while in RESP, stale response during reset is dropped.
    exp_req.push_back('{addr: 28'h0000077, rw: 1'b0});
    ic_mem_req_valid = 1'b1; ic_mem_req_addr = 28'h0000077; ic_mem_req_rw = 1'b0;
    wait_accept("t6_accept");
    step();
    ic_mem_req_valid = 1'b0;
    reset = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = fill(8'hDE);
    @(negedge clk);
    check("t6_no_ic_resp", ic_mem_resp_valid, 1'b0);
    check("t6_no_dc_resp", dc_mem_resp_valid, 1'b0);
    step();
    reset = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    check("t6_err_clear", protocol_err, 1'b0);
    step();
    exp_req.push_back('{addr: 28'h0000088, rw: 1'b0});
    exp_resp.push_back('{client: CLIENT_DC, data: fill(8'h88)});
    dc_mem_req_valid = 1'b1; dc_mem_req_addr = 28'h0000088; dc_mem_req_rw = 1'b0;
    wait_accept("t6_dc_accept");
    step();
    dc_mem_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = fill(8'h88);
    step();
    mem_resp_valid = 1'b0;
    step();

    check("end_req_drained", exp_req.size(), 0);
    check("end_resp_drained", exp_resp.size(), 0);
    check("end_wdata_drained", exp_wdat.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-client arbiter that merges the instruction-cache and data-cache memory ports onto the single backing-memory port.
- Sits directly downstream of both cache instances.
- Owns one transaction at a time. A read transaction is a request beat plus a response beat. A write transaction is a request beat plus a data beat.
- Routes each memory response back to the client that owns the transaction. Client-side ports are protocol-identical to the cache memory port.

Parameters:
- MEM_DATA_BITS, 128, memory beat width.
- MEM_ADDR_BITS, 28, beat address width (30-bit word address minus 2).
- MASK_BITS, MEM_DATA_BITS/8, byte-mask width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- {ic,dc}_mem_req_valid  input  1  client request valid.
- {ic,dc}_mem_req_ready  output  1  request accepted when valid&ready.
- {ic,dc}_mem_req_addr  input  MEM_ADDR_BITS  beat address.
- {ic,dc}_mem_req_rw  input  1  1 = write, 0 = read.
- {ic,dc}_mem_req_data_valid  input  1  write-data beat valid.
- {ic,dc}_mem_req_data_ready  output  1  write-data beat accepted.
- {ic,dc}_mem_req_data_bits  input  MEM_DATA_BITS  write data.
- {ic,dc}_mem_req_data_mask  input  MASK_BITS  byte mask.
- {ic,dc}_mem_resp_valid  output  1  read response beat for this client.
- {ic,dc}_mem_resp_data  output  MEM_DATA_BITS  read data, broadcast to both clients.
- mem_req_valid, mem_req_ready, mem_req_addr, mem_req_rw, mem_req_data_valid, mem_req_data_ready, mem_req_data_bits, mem_req_data_mask, mem_resp_valid, mem_resp_data: memory-side equivalents, opposite directions, same widths.
- protocol_err  output  1  sticky flag: a response arrived with no owner.

Behaviour:
- FSM states: IDLE, REQ, WDATA, RESP. Registers: owner (0 = ic, 1 = dc) and last_grant.
- Reset (synchronous): state = IDLE, owner = 0, last_grant = ic, protocol_err = 0.
  - All client and memory valid/ready outputs read 0 while reset is high and in IDLE.
  - A reset mid-transaction abandons it. No response is forwarded in the reset cycle.
- IDLE:
  - If exactly one client has req_valid, latch it as owner and go to REQ.
  - If both are valid, grant the client that is not last_grant. The first tie after reset therefore goes to dc.
  - No ready is asserted in IDLE, so arbitration costs 1 cycle.
- REQ:
  - mem_req_valid = owner req_valid. mem_req_addr and mem_req_rw are muxed combinationally from owner.
  - Owner req_ready = mem_req_ready. Non-owner req_ready = 0.
  - On handshake, update last_grant = owner. Then:
    - rw = 1: go to WDATA.
    - rw = 0 and mem_resp_valid in the same cycle: forward the response, go to IDLE.
    - rw = 0 otherwise: go to RESP.
  - If the owner drops req_valid before handshake, return to IDLE (no memory-side effect).
- WDATA:
  - mem_req_data_valid, mem_req_data_bits, mem_req_data_mask come from owner. Owner data_ready = mem_req_data_ready.
  - On handshake, go to IDLE.
  - The data beat may lag the request by any number of cycles (caches lag by 1).
- RESP:
  - Wait for mem_resp_valid. Owner resp_valid = mem_resp_valid for exactly that cycle, then go to IDLE.
  - Non-owner resp_valid is 0 in every state.
- Unexpected mem_resp_valid (in IDLE or WDATA): dropped, protocol_err set to 1. It clears only on reset.
- Datapath is fully combinational. Address and data never cross between clients. No buffering.
- A 4-beat cache refill therefore re-arbitrates every beat; interleaving across clients is legal.
- Throughput: one read beat per 3 cycles (IDLE, REQ, RESP) with a 1-cycle memory.

Decomposition:
- Shared package holds the state encoding constants (IDLE/REQ/WDATA/RESP), client ids (CLIENT_IC = 0, CLIENT_DC = 1), and MEM_DATA_BITS/MEM_ADDR_BITS derivations.
- One sub-module is natural: rr_arb2, a 2-input round-robin grant with a last_grant register.
- Muxing and FSM live in mem_arbiter.

Test Plan:
1. ic read alone, addr 0x0000123, memory responds 2 cycles after accept with data 0xA5..A5.
   - Required: ic_mem_resp_valid high for 1 cycle with 0xA5..A5; dc_mem_resp_valid stays 0.
2. ic and dc request in the same cycle right after reset.
   - Required: dc granted first. Next tie grants ic. Third tie grants dc.
3. dc write, addr 0x0ABCDEF; data beat 0x1122..FF, mask 0xFFFF, presented 1 cycle after accept; mem_req_data_ready delayed 3 cycles.
   - Required: mem sees exactly one req (rw = 1) and one data beat with matching bits; ic_mem_req_ready is 0 throughout.
4. mem_resp_valid pulsed in IDLE.
   - Required: protocol_err = 1 and stays 1; neither resp_valid asserts. After reset, protocol_err = 0.
5. Read accepted with mem_resp_valid in the same cycle.
   - Required: response forwarded that cycle; FSM in IDLE next cycle.
6. Reset asserted in RESP, then the stale response arrives.
   - Required: no client resp_valid; FSM restarts cleanly on the next request.
